// File: rtl/uart_to_bus_pkg.sv
// Shared definitions for the UART-to-bus write initiator.
package uart_to_bus_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_REQ      = 3'd1;
    localparam logic [2:0] ST_SEND     = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

endpackage

// File: rtl/uart_to_bus_byte_fifo.sv
// Synchronous byte FIFO; a push while full is accepted only alongside a pop.
module byte_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push_ok, pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_to_bus.sv
// Drains received UART bytes into serial single-writes across a wrapping address window.
module uart_to_bus
    import uart_to_bus_pkg::*;
#(
    parameter int             N          = 8,
    parameter int             ADN        = 12,
    parameter logic [ADN-1:0] BASE_ADDR  = '0,
    parameter int             WIN_SIZE   = 16,
    parameter int             FIFO_DEPTH = 4,
    parameter int             TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] rx_data,
    input  logic         rx_valid,
    input  logic         bus_grant,
    input  logic         slave_ready,
    output logic         bus_request,
    output logic         bus_valid,
    output logic         bus_wren,
    output logic         bus_addr,
    output logic         bus_data,
    output logic         bus_burst_en,
    output logic         busy,
    output logic         rx_overflow,
    output logic         timeout_err
);
    localparam int             CW         = $clog2(ADN) + 1;
    localparam int             TW         = $clog2(TIMEOUT + 1);
    localparam logic [ADN-1:0] WIN_END    = BASE_ADDR + ADN'(WIN_SIZE);
    localparam logic [CW-1:0]  DATA_START = CW'(ADN - N);
    localparam logic [CW-1:0]  LAST_BIT   = CW'(ADN - 1);
    localparam logic [TW-1:0]  T_LAST     = TW'(TIMEOUT - 1);

    logic [2:0]     state, next_state;
    logic [ADN-1:0] addr_sr, addr_ptr, ptr_inc;
    logic [N-1:0]   data_sr, fifo_dout;
    logic [CW-1:0]  bit_cnt;
    logic [TW-1:0]  wait_cnt;
    logic           fifo_full, fifo_empty, push, pop, ack_timeout, data_phase;

    assign pop         = (state == ST_REQ) && bus_grant;
    assign push        = rx_valid && (!fifo_full || pop);
    assign ack_timeout = (state == ST_WAIT_ACK) && !slave_ready && (wait_cnt == T_LAST);
    assign data_phase  = (bit_cnt >= DATA_START);
    assign ptr_inc     = addr_ptr + 1'b1;

    byte_fifo #(.W(N), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (rx_data),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (!fifo_empty) next_state = ST_REQ;
            ST_REQ:      if (bus_grant) next_state = ST_SEND;
            ST_SEND:     if (bit_cnt == LAST_BIT) next_state = ST_WAIT_ACK;
            ST_WAIT_ACK: if (slave_ready || ack_timeout) next_state = ST_DONE;
            ST_DONE:     next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_sr     <= '0;
            data_sr     <= '0;
            bit_cnt     <= '0;
            wait_cnt    <= '0;
            addr_ptr    <= BASE_ADDR;
            rx_overflow <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            rx_overflow <= rx_valid && fifo_full && !pop;
            timeout_err <= ack_timeout;
            case (state)
                ST_REQ: if (bus_grant) begin
                    addr_sr <= addr_ptr;
                    data_sr <= fifo_dout;
                    bit_cnt <= '0;
                end
                ST_SEND: begin
                    addr_sr  <= addr_sr << 1;
                    // Data only advances once it lines up with the trailing address bits.
                    if (data_phase) data_sr <= data_sr << 1;
                    bit_cnt  <= bit_cnt + 1'b1;
                    wait_cnt <= '0;
                end
                ST_WAIT_ACK: wait_cnt <= wait_cnt + 1'b1;
                ST_DONE:     addr_ptr <= (ptr_inc == WIN_END) ? BASE_ADDR : ptr_inc;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus_request = 1'b0;
        bus_valid   = 1'b0;
        bus_wren    = 1'b0;
        bus_addr    = 1'b0;
        bus_data    = 1'b0;
        case (state)
            ST_REQ: bus_request = 1'b1;
            ST_SEND: begin
                bus_request = 1'b1;
                bus_valid   = 1'b1;
                bus_wren    = 1'b1;
                bus_addr    = addr_sr[ADN-1];
                bus_data    = data_phase ? data_sr[N-1] : 1'b0;
            end
            ST_WAIT_ACK: begin
                bus_request = 1'b1;
                bus_wren    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus_burst_en = 1'b0;
    assign busy         = (state != ST_IDLE) || !fifo_empty;

endmodule
